paralelo_serial_multi: RTL

Parametrised parallel-to-serial converter for the PHY transmit path. Accepts a parallel word through a valid/ready handshake and serialises it MSB-first, one bit per CLK. The word width is selected at runtime by PCLK: full, half or quarter of MAX_WIDTH. When no data is pending, the block fills the serial line with a repeating idle symbol so the link never goes silent while enabled.

---
 rtl/paralelo_serial_multi_if.sv | 24 ++
 rtl/paralelo_serial_multi.sv | 106 ++++++++++
 2 files changed

// File: rtl/paralelo_serial_multi_if.sv
// Parallel-word handshake and serial output bundle of the PHY transmit serialiser.
// The slave side is the serialiser; the master side is the producer/line consumer.
interface paralelo_serial_multi_if #(
  parameter int MAX_WIDTH = 32
);
  logic [MAX_WIDTH-1:0] in;
  logic                 in_valid;
  logic                 in_ready;
  logic                 out;
  logic                 out_valid;
  logic                 idle_tx;
  logic                 word_done;
  logic                 mode_err;

  modport master (
    output in, in_valid,
    input  in_ready, out, out_valid, idle_tx, word_done, mode_err
  );

  modport slave (
    input  in, in_valid,
    output in_ready, out, out_valid, idle_tx, word_done, mode_err
  );
endinterface

// File: rtl/paralelo_serial_multi.sv
// Runtime-width parallel-to-serial converter, MSB first, with idle-symbol fill.
//
// state | meaning
// OFF   | disabled or just out of reset; line quiet
// DATA  | shifting an accepted data word
// FILL  | shifting the idle symbol; always completed once started
module paralelo_serial_multi #(
  parameter int                MAX_WIDTH = 32,
  parameter int                IDLE_W    = 8,
  parameter logic [IDLE_W-1:0] IDLE_SYM  = 8'hBC
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    ENB,
  input  logic [1:0]              PCLK,
  paralelo_serial_multi_if.slave  bus
);
  localparam int CW = $clog2(MAX_WIDTH + 1);

  typedef enum logic [1:0] {OFF, DATA, FILL} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [MAX_WIDTH-1:0] shreg, shreg_nxt;
  logic                 valid_q, valid_nxt;
  logic                 idle_q, idle_nxt;
  logic                 done_q, done_nxt;
  logic                 err_q, err_nxt;
  logic                 boundary;

  // cnt counts the bits left including the one on the line, so cnt == 1 is the last bit
  assign boundary     = ENB && ((state == OFF) || (cnt == CW'(1)));
  assign bus.in_ready = boundary;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shreg_nxt = shreg;
    err_nxt   = err_q;
    valid_nxt = 1'b0;
    idle_nxt  = 1'b0;
    done_nxt  = 1'b0;
    if (!ENB) begin
      state_nxt = OFF;
      cnt_nxt   = '0;
      shreg_nxt = '0;
    end else if (boundary) begin
      if (bus.in_valid) begin
        state_nxt = DATA;
        // left-align the selected width so the MSB of the shifter is always the line bit
        unique case (PCLK)
          2'b00: begin
            cnt_nxt   = CW'(MAX_WIDTH);
            shreg_nxt = bus.in;
          end
          2'b01: begin
            cnt_nxt   = CW'(MAX_WIDTH / 2);
            shreg_nxt = bus.in << (MAX_WIDTH / 2);
          end
          default: begin
            cnt_nxt   = CW'(MAX_WIDTH / 4);
            shreg_nxt = bus.in << (3 * MAX_WIDTH / 4);
          end
        endcase
        if (PCLK == 2'b11) err_nxt = 1'b1;
      end else begin
        state_nxt = FILL;
        cnt_nxt   = CW'(IDLE_W);
        shreg_nxt = '0;
        shreg_nxt[MAX_WIDTH-1 -: IDLE_W] = IDLE_SYM;
      end
    end else begin
      shreg_nxt = shreg << 1;
      cnt_nxt   = cnt - CW'(1);
    end
    valid_nxt = (state_nxt != OFF);
    idle_nxt  = (state_nxt == FILL);
    done_nxt  = (state_nxt == DATA) && (cnt_nxt == CW'(1));
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= OFF;
      cnt     <= '0;
      shreg   <= '0;
      valid_q <= 1'b0;
      idle_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      shreg   <= shreg_nxt;
      valid_q <= valid_nxt;
      idle_q  <= idle_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
    end
  end

  assign bus.out       = shreg[MAX_WIDTH-1];
  assign bus.out_valid = valid_q;
  assign bus.idle_tx   = idle_q;
  assign bus.word_done = done_q;
  assign bus.mode_err  = err_q;
endmodule
